regfile_ctrl: RTL
=================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low, with ports clk and rst_n.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- instr_valid  in  1  decode presents a new instruction.
- rs1, rs2  in  5 each  source register addresses.
- instr_ready  out  1  instruction accepted this cycle.
- stall  out  1  equals instr_valid AND NOT instr_ready.
- wb_valid  in  1  writeback request.
- wb_addr  in  5  writeback destination.
- wb_data  in  32  writeback value.
- wb_ready  out  1  writeback accepted.
- ram_ra1, ram_ra2  out  5 each  RAM read addresses, sampled by the RAM at the clk edge.
- ram_rd1, ram_rd2  in  32 each  RAM read data, valid one cycle after the address edge.
- ram_we  out  1  RAM write enable.
- ram_wa  out  5  RAM write address.
- ram_wd  out  32  RAM write data.
- op_valid  out  1  operands valid to execute.
- op_rs1_data, op_rs2_data  out  32 each  operand values.
- op_ready  in  1  execute consumes operands.

Function
REQ-003 SHALL implement FSM states INIT, IDLE, READ, HOLD; INIT is entered on reset.
REQ-004 INIT: 5-bit counter cnt from 0; each cycle ram_we=1, ram_wa=cnt, ram_wd=0; cnt increments; after the cnt==31 cycle -> IDLE (exactly 32 cycles).
REQ-005 INIT: instr_ready=0 and wb_ready=0; wb_valid and instr_valid are ignored.
REQ-006 Outside INIT: wb_ready=1; ram_we = wb_valid AND (wb_addr!=0); ram_wa=wb_addr; ram_wd=wb_data.
REQ-007 Writes to x0 SHALL never reach the RAM and SHALL never be forwarded.
REQ-008 IDLE: instr_ready=1; ram_ra1=rs1 and ram_ra2=rs2 combinationally.
REQ-009 IDLE: instr_valid -> latch rs1/rs2 into ar1/ar2, go READ.
REQ-010 READ: capture operands, set op_valid=1 next cycle, go HOLD; instr_ready=0.
REQ-011 Captured value per operand, highest priority first:
- 0 if its address is 0;
- wb_data if a write to that address occurs in the READ cycle;
- the data of a write to that address accepted in the accept cycle (held in a 1-entry pending register, since the RAM returns old data on same-edge read/write);
- otherwise ram_rdN.
REQ-012 HOLD: op_valid=1; any accepted write to ar1/ar2 (non-zero) SHALL update the held operand at that edge.
REQ-013 HOLD: instr_ready = op_ready; ram_ra = rs1/rs2.
- op_ready AND instr_valid -> latch new addresses, go READ, op_valid=0 next cycle.
- op_ready alone -> IDLE, op_valid=0.
- otherwise stay in HOLD with operands stable except per REQ-012.
REQ-014 Steady-state throughput SHALL be one instruction per 2 cycles; accept-to-op_valid latency SHALL be 2 edges.
REQ-015 Writeback is never back-pressured outside INIT; write and read in the same cycle SHALL both complete.

Reset
REQ-016 rst_n low asynchronously SHALL force: state=INIT, cnt=0, op_valid=0, op data=0, pending register cleared, instr_ready=0, wb_ready=0, ram_we=0 while rst_n is low.
REQ-017 Reset in any state, including mid-INIT or HOLD, SHALL discard the in-flight instruction and restart the full 32-cycle INIT after rst_n rises.

Verification
REQ-018 Release reset -> ram_we=1 for exactly 32 cycles with ram_wa 0..31 and ram_wd=0, then instr_ready=1; wb_valid during INIT yields no write.
REQ-019 Write x5=0xDEADBEEF, then later issue rs1=5, rs2=0 -> op_rs1_data=0xDEADBEEF, op_rs2_data=0, op_valid 2 edges after accept.
REQ-020 Write x7=0x12345678 in the same cycle as accepting rs1=7 -> op_rs1_data=0x12345678; repeat with the write in the READ cycle -> same result.
REQ-021 Hold op_ready=0, write x3=0xA5A5A5A5 while held rs2=3 -> op_rs2_data becomes 0xA5A5A5A5 the next cycle, op_valid stays 1; a write to x0 leaves operands unchanged and ram_we=0.
REQ-022 Back-to-back instr_valid with op_ready=1 -> one op_valid pulse every 2 cycles and stall=1 in each READ cycle; assert rst_n=0 in HOLD -> op_valid=0 immediately and INIT restarts at cnt=0.

Source files
------------

// File: rtl/regfile_ctrl_if.sv
// Bundle of the decode, writeback, RAM and execute signals around the
// register-file controller. The controller connects through the slave
// modport. The surrounding pipeline and RAM connect through the master
// modport.
interface regfile_ctrl_if;
  // Decode side
  logic        instr_valid;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        instr_ready;
  logic        stall;

  // Writeback side
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;

  // Register RAM: synchronous read, one cycle of latency
  logic [4:0]  ram_ra1;
  logic [4:0]  ram_ra2;
  logic [31:0] ram_rd1;
  logic [31:0] ram_rd2;
  logic        ram_we;
  logic [4:0]  ram_wa;
  logic [31:0] ram_wd;

  // Execute side
  logic        op_valid;
  logic [31:0] op_rs1_data;
  logic [31:0] op_rs2_data;
  logic        op_ready;

  modport slave (
    input  instr_valid, rs1, rs2,
    input  wb_valid, wb_addr, wb_data,
    input  ram_rd1, ram_rd2,
    input  op_ready,
    output instr_ready, stall, wb_ready,
    output ram_ra1, ram_ra2, ram_we, ram_wa, ram_wd,
    output op_valid, op_rs1_data, op_rs2_data
  );

  modport master (
    output instr_valid, rs1, rs2,
    output wb_valid, wb_addr, wb_data,
    output ram_rd1, ram_rd2,
    output op_ready,
    input  instr_ready, stall, wb_ready,
    input  ram_ra1, ram_ra2, ram_we, ram_wa, ram_wd,
    input  op_valid, op_rs1_data, op_rs2_data
  );
endinterface

// File: rtl/regfile_ctrl.sv
// Register-file read/write controller in front of a 32x32 synchronous RAM.
// After reset, the controller zeroes all 32 entries. It then serves one
// instruction every two cycles:
//   - In the accept cycle, it issues the RAM read.
//   - In the READ cycle, it captures the operands with writeback forwarding.
//   - In the HOLD state, it holds the operands until execute consumes them.
// Writebacks are never stalled once initialisation is done.
module regfile_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  regfile_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StInit, StIdle, StRead, StHold} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  ar1_q, ar1_d;
  logic [4:0]  ar2_q, ar2_d;
  logic        op_valid_q, op_valid_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        pend_valid_q, pend_valid_d;
  logic [4:0]  pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;

  logic        wr_en;
  logic        instr_ready;
  logic [4:0]  ram_ra1;
  logic [4:0]  ram_ra2;

  // Operand capture: x0, then a write landing now, then the write that raced
  // the RAM read in the accept cycle, then the RAM data itself.
  function automatic logic [31:0] sel_operand(
    input logic [4:0]  addr,
    input logic        wr,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic        pv,
    input logic [4:0]  pa,
    input logic [31:0] pd,
    input logic [31:0] rd
  );
    logic [31:0] val;
    if (addr == 5'd0) begin
      val = 32'd0;
    end else if (wr && (wa == addr)) begin
      val = wd;
    end else if (pv && (pa == addr)) begin
      val = pd;
    end else begin
      val = rd;
    end
    return val;
  endfunction

  // A writeback that actually reaches the RAM (x0 and INIT excluded).
  assign wr_en = (state_q != StInit) && bus.wb_valid && (bus.wb_addr != 5'd0);

  // RAM write port: zero-fill during INIT, otherwise pass writeback through.
  // rst_n gates the enable so that nothing is written while reset is held.
  assign bus.ram_we = rst_n && ((state_q == StInit) || wr_en);
  assign bus.ram_wa = (state_q == StInit) ? cnt_q : bus.wb_addr;
  assign bus.ram_wd = (state_q == StInit) ? 32'd0 : bus.wb_data;

  assign bus.wb_ready    = (state_q != StInit);
  assign bus.instr_ready = instr_ready;
  assign bus.stall       = bus.instr_valid && !instr_ready;
  assign bus.ram_ra1     = ram_ra1;
  assign bus.ram_ra2     = ram_ra2;
  assign bus.op_valid    = op_valid_q;
  assign bus.op_rs1_data = op1_q;
  assign bus.op_rs2_data = op2_q;

  // Next-state, operand capture and read-address steering.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ar1_d       = ar1_q;
    ar2_d       = ar2_q;
    op_valid_d  = op_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    instr_ready = 1'b0;
    ram_ra1     = ar1_q;
    ram_ra2     = ar2_q;

    // The pending entry is only consumed in READ, and the cycle before READ
    // is always the accept cycle, so recording every cycle is sufficient.
    pend_valid_d = wr_en;
    pend_addr_d  = bus.wb_addr;
    pend_data_d  = bus.wb_data;

    unique case (state_q)
      StInit: begin
        ram_ra1 = 5'd0;
        ram_ra2 = 5'd0;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        instr_ready = 1'b1;
        ram_ra1     = bus.rs1;
        ram_ra2     = bus.rs2;
        if (bus.instr_valid) begin
          ar1_d   = bus.rs1;
          ar2_d   = bus.rs2;
          state_d = StRead;
        end
      end

      StRead: begin
        op1_d = sel_operand(ar1_q, wr_en, bus.wb_addr, bus.wb_data,
                            pend_valid_q, pend_addr_q, pend_data_q, bus.ram_rd1);
        op2_d = sel_operand(ar2_q, wr_en, bus.wb_addr, bus.wb_data,
                            pend_valid_q, pend_addr_q, pend_data_q, bus.ram_rd2);
        op_valid_d = 1'b1;
        state_d    = StHold;
      end

      StHold: begin
        instr_ready = bus.op_ready;
        ram_ra1     = bus.rs1;
        ram_ra2     = bus.rs2;
        // Held operands track the register file while execute is stalled.
        if (wr_en && (bus.wb_addr == ar1_q)) begin
          op1_d = bus.wb_data;
        end
        if (wr_en && (bus.wb_addr == ar2_q)) begin
          op2_d = bus.wb_data;
        end
        if (bus.op_ready) begin
          op_valid_d = 1'b0;
          if (bus.instr_valid) begin
            ar1_d   = bus.rs1;
            ar2_d   = bus.rs2;
            state_d = StRead;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StInit;
      end
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      cnt_q        <= 5'd0;
      ar1_q        <= 5'd0;
      ar2_q        <= 5'd0;
      op_valid_q   <= 1'b0;
      op1_q        <= 32'd0;
      op2_q        <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 5'd0;
      pend_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ar1_q        <= ar1_d;
      ar2_q        <= ar2_d;
      op_valid_q   <= op_valid_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

endmodule
